// File: rtl/sram_ctrl.sv
// ---------------------------------------------------------------------------
// sram_ctrl
// Request/response front-end for a 128x8 synchronous SRAM. It accepts one read
// or write at a time over a valid/ready handshake, drives the SRAM pins from
// registered copies of the request, and returns read data on a valid/ready
// response channel.
//
// Optional build macro: SRAM_CLEAR_EN
//   When defined, reset enters a CLEAR state that writes zero to every SRAM
//   address before the first request is accepted.
//   When undefined, reset goes straight to IDLE.
//
// Reset is synchronous and active-low. The SRAM's active-high reset is
// driven with ~reset by the level above.
// ---------------------------------------------------------------------------
module sram_ctrl #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    // Request channel
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    // Response channel
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    // Status
    output logic              busy,
    // SRAM pins
    output logic              mem_cs,
    output logic              mem_we,
    output logic              mem_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // -----------------------------------------------------------------------
    // State encoding
    // -----------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR      = 3'd1,
        S_RD_ADDR = 3'd2,
        S_RD_DATA = 3'd3,
        S_RSP     = 3'd4
`ifdef SRAM_CLEAR_EN
        ,
        S_CLEAR   = 3'd5
`endif
    } state_t;

`ifdef SRAM_CLEAR_EN
    localparam state_t RESET_STATE = S_CLEAR;
`else
    localparam state_t RESET_STATE = S_IDLE;
`endif

    state_t r_state;
    state_t w_next_state;

    // Captured request; these drive the SRAM address/data pins so that the
    // pins never follow req_* combinationally.
    logic [ADDR_W-1:0] r_addr_q;
    logic [DATA_W-1:0] r_wdata_q;
    logic [DATA_W-1:0] r_rsp_data;

    logic w_accept;

    // A request is taken only in IDLE; everywhere else req_valid is ignored
    // and the requester must keep holding it.
    assign w_accept = (r_state == S_IDLE) && req_valid;

`ifdef SRAM_CLEAR_EN
    // -----------------------------------------------------------------------
    // Post-reset sweep counter
    // -----------------------------------------------------------------------
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              w_clr_last;

    assign w_clr_last = (r_clr_cnt == '1);

    // Sweep address: restarts at 0 on every reset, advances once per CLEAR cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_clr_cnt <= '0;
        end else if (r_state == S_CLEAR) begin
            r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
        end
    end
`endif

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // Advance the FSM; reset overrides any in-flight request or response.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values, independent of block ordering.
        if (!reset) begin
            r_state <= RESET_STATE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and Moore output decode
    // -----------------------------------------------------------------------
    // Strobes, busy and the handshake outputs depend on r_state only.
    always_comb begin
        // NOTE: every output gets a default before the case so that no path
        // leaves a signal unassigned, which would infer a latch.
        w_next_state = r_state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        busy         = 1'b1;
        mem_cs       = 1'b0;
        mem_we       = 1'b0;
        mem_oe       = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    w_next_state = req_we ? S_WR : S_RD_ADDR;
                end
            end
            S_WR: begin
                // SRAM commits r_wdata_q at the next edge.
                mem_cs       = 1'b1;
                mem_we       = 1'b1;
                w_next_state = S_IDLE;
            end
            S_RD_ADDR: begin
                // SRAM loads its output buffer at the next edge.
                mem_cs       = 1'b1;
                w_next_state = S_RD_DATA;
            end
            S_RD_DATA: begin
                // Buffer is on mem_rdata; the repeated SRAM read of the same
                // address only reloads the same value.
                mem_cs       = 1'b1;
                mem_oe       = 1'b1;
                w_next_state = S_RSP;
            end
            S_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
`ifdef SRAM_CLEAR_EN
            S_CLEAR: begin
                mem_cs = 1'b1;
                mem_we = 1'b1;
                if (w_clr_last) begin
                    w_next_state = S_IDLE;
                end
            end
`endif
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Request capture and response data register
    // -----------------------------------------------------------------------
    // Latch the request on accept; latch SRAM read data as RD_DATA ends.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_addr_q   <= '0;
            r_wdata_q  <= '0;
            r_rsp_data <= '0;
        end else begin
            if (w_accept) begin
                r_addr_q  <= req_addr;
                r_wdata_q <= req_wdata;
            end
            if (r_state == S_RD_DATA) begin
                r_rsp_data <= mem_rdata;
            end
        end
    end

    assign rsp_data = r_rsp_data;

    // -----------------------------------------------------------------------
    // SRAM address/data pin selection
    // -----------------------------------------------------------------------
    // Captured request drives the pins, except during the clear sweep.
    always_comb begin
        mem_addr  = r_addr_q;
        mem_wdata = r_wdata_q;
`ifdef SRAM_CLEAR_EN
        if (r_state == S_CLEAR) begin
            mem_addr  = r_clr_cnt;
            mem_wdata = '0;
        end
`endif
    end

    // -----------------------------------------------------------------------
    // Protocol invariants
    // -----------------------------------------------------------------------
    // A write or output-enable never happens without chip select, and the
    // SRAM is never asked to write and drive data at the same time.
    a_we_needs_cs: assert property (@(posedge clk) disable iff (!reset)
        mem_we |-> mem_cs);
    a_oe_needs_cs: assert property (@(posedge clk) disable iff (!reset)
        mem_oe |-> mem_cs);
    a_we_oe_excl: assert property (@(posedge clk) disable iff (!reset)
        !(mem_we && mem_oe));

endmodule
